// File: rtl/two_parallel_sched.sv
// two_parallel_sched: packs a serial sample stream into (din1, din2) pairs for
// a two-parallel filter, tracks the filter latency with per-word valid flags,
// and re-serializes the two result words onto a valid/ready output stream.
// A flush pads an odd trailing sample with zero and drains the filter pipe.
module two_parallel_sched #(
    parameter int DW  = 16,
    parameter int OW  = 64,
    parameter int LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          flush,
    output logic          flush_done,
    output logic          fir_ce,
    output logic [DW-1:0] fir_din1,
    output logic [DW-1:0] fir_din2,
    input  logic [OW-1:0] fir_dout1,
    input  logic [OW-1:0] fir_dout2,
    output logic [OW-1:0] m_data,
    output logic          m_valid,
    input  logic          m_ready
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HALF  = 2'd1,
        ST_FULL  = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_next;

    logic [DW-1:0] r_slot_a;
    logic [DW-1:0] r_slot_b;
    logic [1:0]    r_pair_flags;     // bit0 = din1 word real, bit1 = din2 word real
    logic          r_flush_pend;
    logic [3:0]    r_drain_cnt;
    logic [1:0]    r_pipe [LAT];     // flags travelling alongside the filter pipeline
    logic [OW-1:0] r_buf1;
    logic [OW-1:0] r_buf2;
    logic [1:0]    r_bflag;          // words still waiting in the output buffer
    logic [DW-1:0] r_din1;
    logic [DW-1:0] r_din2;

    logic          w_accept;
    logic          w_buf_free;
    logic          w_issue;
    logic          w_pipe_any;
    logic          w_drain_last;
    logic [1:0]    w_issue_flags;
    logic [1:0]    w_exit_flags;

    assign w_accept     = s_valid & s_ready;
    assign w_exit_flags = r_pipe[LAT-1];
    assign w_drain_last = (r_drain_cnt == 4'(LAT - 1));
    assign m_valid      = |r_bflag;
    assign m_data       = r_bflag[0] ? r_buf1 : r_buf2;

    // Buffer can take a new capture if empty, or if its only remaining word leaves now
    assign w_buf_free = (r_bflag == 2'b00) |
                        (m_ready & ((r_bflag == 2'b01) | (r_bflag == 2'b10)));

    // Any real word still inside the filter pipeline
    always_comb begin
        w_pipe_any = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            w_pipe_any = w_pipe_any | (|r_pipe[i]);
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (r_flush_pend) begin
                    if (w_pipe_any) w_state_next = ST_DRAIN;
                end else if (w_accept) begin
                    w_state_next = ST_HALF;
                end
            end
            ST_HALF: begin
                if (r_flush_pend || w_accept) w_state_next = ST_FULL;
            end
            ST_FULL: begin
                if (w_issue) w_state_next = ST_EMPTY;
            end
            ST_DRAIN: begin
                if (w_issue && w_drain_last) w_state_next = ST_EMPTY;
            end
            default: w_state_next = ST_EMPTY;
        endcase
    end

    // Outputs decoded from the state: handshake, issue strobe, filter inputs, flush completion
    always_comb begin
        s_ready       = rst & ((r_state == ST_EMPTY) | (r_state == ST_HALF)) & ~r_flush_pend;
        w_issue       = rst & ((r_state == ST_FULL) | (r_state == ST_DRAIN)) & w_buf_free;
        fir_ce        = w_issue;
        w_issue_flags = (r_state == ST_DRAIN) ? 2'b00 : r_pair_flags;
        fir_din1      = r_din1;
        fir_din2      = r_din2;
        if (w_issue) begin
            fir_din1 = (r_state == ST_DRAIN) ? '0 : r_slot_a;
            fir_din2 = (r_state == ST_DRAIN) ? '0 : r_slot_b;
        end
        flush_done    = rst & (r_state == ST_EMPTY) & r_flush_pend & ~w_pipe_any &
                        (r_bflag == 2'b00);
    end

    // Sample slots, flush latch, drain counter, flag pipe and output buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_slot_a     <= '0;
            r_slot_b     <= '0;
            r_pair_flags <= 2'b00;
            r_flush_pend <= 1'b0;
            r_drain_cnt  <= '0;
            r_buf1       <= '0;
            r_buf2       <= '0;
            r_bflag      <= 2'b00;
            r_din1       <= '0;
            r_din2       <= '0;
            for (int i = 0; i < LAT; i++) begin
                r_pipe[i] <= 2'b00;
            end
        end else begin
            if (w_accept && r_state == ST_EMPTY) begin
                r_slot_a <= s_data;
            end
            if (r_state == ST_HALF) begin
                if (r_flush_pend) begin
                    r_slot_b     <= '0;
                    r_pair_flags <= 2'b01;
                end else if (w_accept) begin
                    r_slot_b     <= s_data;
                    r_pair_flags <= 2'b11;
                end
            end

            if (flush_done) begin
                r_flush_pend <= 1'b0;
            end else if (flush) begin
                r_flush_pend <= 1'b1;
            end

            if (w_issue && r_state == ST_DRAIN) begin
                r_drain_cnt <= w_drain_last ? 4'd0 : r_drain_cnt + 4'd1;
            end

            if (w_issue) begin
                for (int i = LAT - 1; i > 0; i--) begin
                    r_pipe[i] <= r_pipe[i-1];
                end
                r_pipe[0] <= w_issue_flags;
                r_buf1    <= fir_dout1;
                r_buf2    <= fir_dout2;
                r_bflag   <= w_exit_flags;
                r_din1    <= fir_din1;
                r_din2    <= fir_din2;
            end else if (m_valid && m_ready) begin
                // Retire the word currently presented (din1 slot first)
                if (r_bflag[0]) r_bflag[0] <= 1'b0;
                else            r_bflag[1] <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_two_parallel_sched.sv
// Bench for two_parallel_sched: identity stub filter, queue-based reference
// of expected filter pairs and output words, directed and random streams.
module tb_two_parallel_sched;

    localparam int DW  = 16;
    localparam int OW  = 64;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic          flush = 1'b0;
    logic          flush_done;
    logic          fir_ce;
    logic [DW-1:0] fir_din1;
    logic [DW-1:0] fir_din2;
    logic [OW-1:0] fir_dout1;
    logic [OW-1:0] fir_dout2;
    logic [OW-1:0] m_data;
    logic          m_valid;
    logic          m_ready = 1'b1;

    two_parallel_sched #(.DW(DW), .OW(OW), .LAT(LAT)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .flush     (flush),
        .flush_done(flush_done),
        .fir_ce    (fir_ce),
        .fir_din1  (fir_din1),
        .fir_din2  (fir_din2),
        .fir_dout1 (fir_dout1),
        .fir_dout2 (fir_dout2),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready)
    );

    always #5 clk = ~clk;

    // Identity stub filter: each enable shifts the pair in, output is LAT enables old
    logic [DW-1:0] st1 [LAT] = '{default: '0};
    logic [DW-1:0] st2 [LAT] = '{default: '0};
    always @(posedge clk) begin
        if (fir_ce) begin
            for (int i = LAT - 1; i > 0; i--) begin
                st1[i] <= st1[i-1];
                st2[i] <= st2[i-1];
            end
            st1[0] <= fir_din1;
            st2[0] <= fir_din2;
        end
    end
    assign fir_dout1 = {{(OW-DW){st1[LAT-1][DW-1]}}, st1[LAT-1]};
    assign fir_dout2 = {{(OW-DW){st2[LAT-1][DW-1]}}, st2[LAT-1]};

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
    } pair_t;

    pair_t         exp_issue[$];
    logic [OW-1:0] exp_out[$];
    logic [DW-1:0] held = '0;
    bit            held_v = 1'b0;
    int            stream_n = 0;
    int            flush_exp = 0;
    int            flush_seen = 0;
    int            last_fd_cyc = -1;
    int            mr_mode = 0;

    function automatic logic [OW-1:0] sx(input logic [DW-1:0] v);
        return {{(OW-DW){v[DW-1]}}, v};
    endfunction

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Reference: samples pair up in arrival order; a flush pads an odd one with
    // zero and, if the stream carried anything, adds LAT zero pairs of drain.
    task automatic model_accept(input logic [DW-1:0] v);
        exp_out.push_back(sx(v));
        stream_n++;
        if (held_v) begin
            exp_issue.push_back('{a: held, b: v});
            held_v = 1'b0;
        end else begin
            held   = v;
            held_v = 1'b1;
        end
    endtask

    task automatic model_flush();
        if (held_v) begin
            exp_issue.push_back('{a: held, b: '0});
            held_v = 1'b0;
        end
        if (stream_n > 0) begin
            for (int i = 0; i < LAT; i++) exp_issue.push_back('{a: '0, b: '0});
        end
        stream_n = 0;
        flush_exp++;
    endtask

    task automatic model_reset();
        exp_issue.delete();
        exp_out.delete();
        held_v   = 1'b0;
        stream_n = 0;
    endtask

    // Monitor: compares every filter issue and every accepted output word
    initial begin
        pair_t         p;
        logic [OW-1:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (fir_ce) begin
                    check("ce_while_buffer_blocked", 64'(!m_valid || m_ready), 64'd1);
                    if (exp_issue.size() == 0) begin
                        check("unexpected_issue", 64'(exp_issue.size()), 64'd1);
                    end else begin
                        p = exp_issue.pop_front();
                        check("fir_din1", 64'(fir_din1), 64'(p.a));
                        check("fir_din2", 64'(fir_din2), 64'(p.b));
                    end
                end
                if (m_valid && m_ready) begin
                    if (exp_out.size() == 0) begin
                        check("unexpected_output", 64'(exp_out.size()), 64'd1);
                    end else begin
                        e = exp_out.pop_front();
                        check("m_data", m_data, e);
                    end
                end
                if (flush_done) begin
                    flush_seen++;
                    last_fd_cyc = cyc;
                end
            end
        end
    end

    // Output backpressure patterns
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk);
            #1;
            case (mr_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (ph % 4 == 0);
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [DW-1:0] v, input int gap);
        int bound = 0;
        repeat (gap) tick();
        s_valid = 1'b1;
        s_data  = v;
        forever begin
            @(negedge clk);
            if (s_ready) begin
                model_accept(v);
                break;
            end
            bound++;
            if (bound > 200) begin
                check("s_ready_timeout", 64'(s_ready), 64'd1);
                break;
            end
        end
        tick();
        s_valid = 1'b0;
    endtask

    task automatic do_flush(output int fc);
        int bound = 0;
        flush = 1'b1;
        fc    = cyc;
        model_flush();
        tick();
        flush = 1'b0;
        while (flush_seen < flush_exp && bound < 400) begin
            tick();
            bound++;
        end
        check("flush_done_count", 64'(flush_seen), 64'(flush_exp));
        repeat (LAT + 4) tick();
        check("flush_done_count_after", 64'(flush_seen), 64'(flush_exp));
        check("outputs_drained", 64'(exp_out.size()), 64'd0);
        check("issues_drained", 64'(exp_issue.size()), 64'd0);
    endtask

    initial begin
        int fc;
        int len;

        // Reset held with input offered
        rst     = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'h1234;
        repeat (3) begin
            @(negedge clk);
            check("rst_s_ready", 64'(s_ready), 64'd0);
            check("rst_m_valid", 64'(m_valid), 64'd0);
            check("rst_fir_ce", 64'(fir_ce), 64'd0);
            check("rst_fir_din1", 64'(fir_din1), 64'd0);
            check("rst_fir_din2", 64'(fir_din2), 64'd0);
            check("rst_m_data", m_data, 64'd0);
            check("rst_flush_done", 64'(flush_done), 64'd0);
        end
        tick();
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 64'(s_ready), 64'd1);
        tick();

        // Even stream
        send(16'd1, 0); send(16'd2, 0); send(16'd3, 0); send(16'd4, 0);
        do_flush(fc);

        // Odd stream, last pair padded
        send(16'd5, 0); send(-16'sd6, 0); send(16'd7, 0);
        do_flush(fc);

        // Backpressure 1 on / 3 off
        mr_mode = 1;
        for (int i = 1; i <= 8; i++) send(16'(i), 0);
        do_flush(fc);
        mr_mode = 0;
        repeat (4) tick();

        // Flush with nothing in flight
        do_flush(fc);
        check("empty_flush_latency", 64'(last_fd_cyc), 64'(fc + 1));

        // Reset while a sample is held and a pair sits in the pipe
        send(16'd1, 0); send(16'd2, 0); send(16'd9, 0);
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        tick();
        rst = 1'b1;
        repeat (6) tick();
        check("post_midrst_m_valid", 64'(m_valid), 64'd0);
        send(16'd10, 0); send(16'd11, 0);
        do_flush(fc);

        // Random streams with random gaps and random output backpressure
        mr_mode = 2;
        for (int s = 0; s < 12; s++) begin
            len = $urandom_range(1, 9);
            for (int k = 0; k < len; k++) begin
                send(16'($urandom), $urandom_range(0, 2));
            end
            repeat ($urandom_range(0, 3)) tick();
            do_flush(fc);
        end
        mr_mode = 0;
        repeat (5) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global time bound
    initial begin
        #2000000;
        miscompares++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
    end

endmodule
